// File: rtl/cnt_token_pkg.sv
// Shared types and the saturating accumulate helper for the count-to-token path.
package cnt_token_pkg;

   typedef enum logic {ST_INIT, ST_RUN} cnt_tok_state_e;

   // Widest accumulator the helper supports; callers zero-extend into this.
   localparam int unsigned SAT_W = 32;

   // Returns {saturated, pending + delta - take clipped at max_val}.
   // take is only asserted when pending is non-zero, so the sum never underflows.
   function automatic logic [SAT_W:0] sat_add(
      input logic [SAT_W-1:0] pending,
      input logic [SAT_W-1:0] delta,
      input logic             take,
      input logic [SAT_W-1:0] max_val
   );
      logic [SAT_W:0] sum;
      sum = {1'b0, pending} + {1'b0, delta} - {{SAT_W{1'b0}}, take};
      if (sum > {1'b0, max_val}) begin
         sat_add = {1'b1, max_val};
      end else begin
         sat_add = {1'b0, sum[SAT_W-1:0]};
      end
   endfunction

endpackage

// File: rtl/cnt_delta.sv
// Registers the previous count sample and yields the modulo-2^W increment
// against the current sample. Reusable by any consumer of a free-running count.
module cnt_delta #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] cnt_in,
   output logic [W-1:0] delta
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Unsigned subtraction handles the 2^W-1 -> 0 wrap without a special case.
   assign delta = cnt_in - cnt_q;

endmodule

// File: rtl/cnt_token_extractor.sv
// Turns a synchronized free-running count into a stream of valid/ready tokens.
// Optional step-plausibility flag is compiled in with CNT_TOKEN_STEP_CHECK_EN.
//
// state   | meaning
// ST_INIT | first cycle out of reset: baseline captured, nothing counted
// ST_RUN  | increments accumulate into pending, one token per handshake
module cnt_token_extractor
   import cnt_token_pkg::*;
#(
   parameter int unsigned W        = 8,
   parameter int unsigned PW       = 12,
   parameter int unsigned MAX_STEP = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  cnt_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] pending,
   output logic          ovf,
   input  logic          clr_err
`ifdef CNT_TOKEN_STEP_CHECK_EN
   ,
   output logic          err_step
`endif
);

   localparam logic [PW-1:0] PEND_MAX = '1;

   cnt_tok_state_e state_q, state_d;
   logic [PW-1:0]  pending_q, pending_d;
   logic           ovf_q, ovf_d;
   logic [W-1:0]   delta;
   logic           take;
   logic [SAT_W:0] sat_res;

   cnt_delta #(.W(W)) u_delta (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt_in (cnt_in),
      .delta  (delta)
   );

   assign out_valid = (state_q == ST_RUN) && (pending_q != '0);
   assign take      = out_valid && out_ready;
   assign sat_res   = sat_add(SAT_W'(pending_q), SAT_W'(delta), take, SAT_W'(PEND_MAX));

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      ovf_d     = ovf_q & ~clr_err;
      if (state_q == ST_INIT) begin
         state_d = ST_RUN;
      end else begin
         pending_d = sat_res[PW-1:0];
         // A fresh saturation in the clearing cycle keeps the flag set.
         ovf_d     = ovf_d | sat_res[SAT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_INIT;
         pending_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   assign pending = pending_q;
   assign ovf     = ovf_q;

   logic unused_sat;
   assign unused_sat = ^sat_res[SAT_W-1:PW];

`ifdef CNT_TOKEN_STEP_CHECK_EN
   logic err_step_q, err_step_d;

   // Large jumps point at a sync glitch or clock-ratio violation; still counted.
   always_comb begin
      err_step_d = err_step_q & ~clr_err;
      if (state_q == ST_RUN && 32'(delta) > MAX_STEP) begin
         err_step_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_step_q <= 1'b0;
      end else begin
         err_step_q <= err_step_d;
      end
   end

   assign err_step = err_step_q;
`else
   logic unused_max_step;
   assign unused_max_step = (MAX_STEP != 0);
`endif

endmodule

// File: tb/tb_cnt_token_extractor.sv
// Randomized and directed bench for cnt_token_extractor: a PW=12 and a PW=4
// instance share stimulus and are checked against a per-instance token model.
module tb_cnt_token_extractor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  cnt_in;
   logic        out_ready;
   logic        clr_err;
   logic        out_valid0, out_valid1;
   logic [11:0] pending0;
   logic [3:0]  pending1;
   logic        ovf0, ovf1;
`ifdef CNT_TOKEN_STEP_CHECK_EN
   logic        err_step0, err_step1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cnt_token_extractor #(.W(8), .PW(12), .MAX_STEP(2)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt_in    (cnt_in),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .pending   (pending0),
      .ovf       (ovf0),
      .clr_err   (clr_err)
`ifdef CNT_TOKEN_STEP_CHECK_EN
      ,
      .err_step  (err_step0)
`endif
   );

   cnt_token_extractor #(.W(8), .PW(4), .MAX_STEP(2)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt_in    (cnt_in),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .pending   (pending1),
      .ovf       (ovf1),
      .clr_err   (clr_err)
`ifdef CNT_TOKEN_STEP_CHECK_EN
      ,
      .err_step  (err_step1)
`endif
   );

   // Behavioural model, one slot per instance.
   int m_max [2] = '{4095, 15};
   bit m_run [2];
   int m_prev[2];
   int m_pend[2];
   bit m_ovf [2];
   bit m_err [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_run[i] = 0; m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0; m_err[i] = 0;
         end else begin
            if (clr_err) begin
               m_ovf[i] = 0;
               m_err[i] = 0;
            end
            if (!m_run[i]) begin
               m_run[i]  = 1;
               m_prev[i] = int'(cnt_in);
            end else begin
               int d, s;
               d = (int'(cnt_in) - m_prev[i] + 256) % 256;
               s = m_pend[i] + d - ((m_pend[i] != 0 && out_ready) ? 1 : 0);
               if (s > m_max[i]) begin
                  m_pend[i] = m_max[i];
                  m_ovf[i]  = 1;
               end else begin
                  m_pend[i] = s;
               end
               if (d > 2) m_err[i] = 1;
               m_prev[i] = int'(cnt_in);
            end
         end
      end
   endtask

   task automatic compare();
      chk("pending0",  32'(pending0),   32'(m_pend[0]));
      chk("valid0",    32'(out_valid0), 32'(m_run[0] && m_pend[0] != 0));
      chk("ovf0",      32'(ovf0),       32'(m_ovf[0]));
      chk("pending1",  32'(pending1),   32'(m_pend[1]));
      chk("valid1",    32'(out_valid1), 32'(m_run[1] && m_pend[1] != 0));
      chk("ovf1",      32'(ovf1),       32'(m_ovf[1]));
`ifdef CNT_TOKEN_STEP_CHECK_EN
      chk("err_step0", 32'(err_step0),  32'(m_err[0]));
      chk("err_step1", 32'(err_step1),  32'(m_err[1]));
`endif
   endtask

   task automatic cyc(input logic [7:0] c, input logic rdy, input logic clr, input logic rs);
      cnt_in    = c;
      out_ready = rdy;
      clr_err   = clr;
      rst_n     = rs;
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      logic [7:0] c;
      rst_n = 1'b0; cnt_in = 8'h37; out_ready = 1'b0; clr_err = 1'b0;

      // Reset, then release with a static count: baseline only, no tokens.
      for (int i = 0; i < 3; i++) cyc(8'h37, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cyc(8'h37, 1'b0, 1'b0, 1'b1);
      chk("baseline_pend", 32'(pending0), 32'd0);
      chk("baseline_valid", 32'(out_valid0), 32'd0);

      // Single steps with no consumer, then drain.
      for (int i = 0; i < 2; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0);
      cyc(8'h00, 1'b0, 1'b0, 1'b1);
      cyc(8'h01, 1'b0, 1'b0, 1'b1);
      chk("first_step_valid", 32'(out_valid0), 32'd1);
      cyc(8'h02, 1'b0, 1'b0, 1'b1);
      cyc(8'h03, 1'b0, 1'b0, 1'b1);
      chk("steps_pend", 32'(pending0), 32'd3);
      for (int i = 0; i < 3; i++) cyc(8'h03, 1'b1, 1'b0, 1'b1);
      chk("drain_pend", 32'(pending0), 32'd0);
      chk("drain_valid", 32'(out_valid0), 32'd0);

      // Wrap through 0xFF -> 0x00, then simultaneous step and take.
      for (int i = 0; i < 2; i++) cyc(8'hFD, 1'b0, 1'b0, 1'b0);
      cyc(8'hFD, 1'b0, 1'b0, 1'b1);
      cyc(8'hFE, 1'b0, 1'b0, 1'b1);
      cyc(8'hFF, 1'b0, 1'b0, 1'b1);
      cyc(8'h00, 1'b0, 1'b0, 1'b1);
      cyc(8'h01, 1'b0, 1'b0, 1'b1);
      chk("wrap_pend", 32'(pending0), 32'd4);
      cyc(8'h02, 1'b1, 1'b0, 1'b1);
      chk("net_zero_pend", 32'(pending0), 32'd4);

      // Saturate the narrow instance, then clear the sticky flag.
      c = 8'h02;
      for (int i = 0; i < 20; i++) begin
         c = c + 8'd1;
         cyc(c, 1'b0, 1'b0, 1'b1);
      end
      chk("sat_pend", 32'(pending1), 32'd15);
      chk("sat_ovf", 32'(ovf1), 32'd1);
      chk("wide_pend", 32'(pending0), 32'd24);
      cyc(c, 1'b0, 1'b1, 1'b1);
      chk("clr_ovf", 32'(ovf1), 32'd0);
      chk("clr_pend", 32'(pending1), 32'd15);

      // Random traffic: mostly small steps, occasional jumps, clears and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 5) c = 8'($urandom_range(0, 255));
         else c = c + 8'($urandom_range(0, 3));
         cyc(c, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 199) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
